// File: rtl/vend_ctrl_multi.sv
// Multi-product vending controller: credits coins, vends priced/stocked products, returns greedy change.
// Latency: all pulses/outputs are registered and appear the cycle after the causing input.
// Backpressure: change coins wait on chg_ready_i; chg_code_o holds while chg_valid_o && !chg_ready_i.
module vend_ctrl_multi #(
  parameter int N_PROD      = 4,
  parameter int CREDIT_W    = 8,
  parameter int STOCK_W     = 4,
  parameter int INIT_STOCK  = 9,
  parameter logic [N_PROD*CREDIT_W-1:0] PRICES    = {8'd50, 8'd40, 8'd30, 8'd20},
  parameter logic [4*CREDIT_W-1:0]      COIN_VALS = {8'd100, 8'd50, 8'd20, 8'd10},
  parameter int MAX_CREDIT  = 200,
  parameter int TIMEOUT_CYC = 30000,
  parameter int IDX_W       = (N_PROD > 1) ? $clog2(N_PROD) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin_valid_i,
  input  logic [1:0]          coin_code_i,
  input  logic                sel_valid_i,
  input  logic [IDX_W-1:0]    sel_idx_i,
  input  logic                cancel_i,
  input  logic                restock_i,
  input  logic                chg_ready_i,
  output logic                coin_reject_o,
  output logic                vend_valid_o,
  output logic [IDX_W-1:0]    vend_idx_o,
  output logic [1:0]          sel_err_o,
  output logic                chg_valid_o,
  output logic [1:0]          chg_code_o,
  output logic [CREDIT_W-1:0] credit_o,
  output logic [N_PROD-1:0]   sold_out_o,
  output logic                busy_o
);

  localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMR_W-1:0]    TMR_LAST   = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [CREDIT_W:0]   MAX_C      = (CREDIT_W + 1)'(MAX_CREDIT);
  localparam logic [STOCK_W-1:0]  STOCK_INIT = STOCK_W'(INIT_STOCK);

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_SOLDOUT = 2'd1;
  localparam logic [1:0] ERR_CREDIT  = 2'd2;
  localparam logic [1:0] ERR_INDEX   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_VEND    = 2'd2,
    S_CHANGE  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [CREDIT_W-1:0]  credit_q, credit_d;
  logic [STOCK_W-1:0]   stock_q [N_PROD];
  logic [STOCK_W-1:0]   stock_d [N_PROD];
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic                 coin_reject_q, coin_reject_d;
  logic                 vend_valid_q, vend_valid_d;
  logic [IDX_W-1:0]     vend_idx_q, vend_idx_d;
  logic [1:0]           sel_err_q, sel_err_d;
  logic [1:0]           chg_code_q, chg_code_d;

  // Unpacked views of the packed price and coin tables.
  logic [CREDIT_W-1:0]  price_a    [N_PROD];
  logic [CREDIT_W-1:0]  coin_val_a [4];

  for (genvar gi = 0; gi < N_PROD; gi++) begin : g_price
    assign price_a[gi] = PRICES[gi*CREDIT_W +: CREDIT_W];
  end

  for (genvar gc = 0; gc < 4; gc++) begin : g_coin
    assign coin_val_a[gc] = COIN_VALS[gc*CREDIT_W +: CREDIT_W];
  end

  // Largest denomination not exceeding amt; table is ascending so the last hit wins.
  function automatic logic [1:0] largest_coin(input logic [CREDIT_W-1:0] amt);
    logic [1:0] code;
    code = 2'd0;
    for (int c = 0; c < 4; c++) begin
      if (COIN_VALS[c*CREDIT_W +: CREDIT_W] <= amt) code = 2'(c);
    end
    return code;
  endfunction

  logic [CREDIT_W:0]    coin_sum;
  logic                 coin_fits;
  logic                 idx_ok;
  logic [CREDIT_W-1:0]  sel_price;
  logic [STOCK_W-1:0]   sel_stock;

  // Coin addition is one bit wider than credit so an over-limit sum cannot wrap.
  assign coin_sum  = {1'b0, credit_q} + {1'b0, coin_val_a[coin_code_i]};
  assign coin_fits = (coin_sum <= MAX_C);
  assign idx_ok    = (int'(sel_idx_i) < N_PROD);
  assign sel_price = price_a[sel_idx_i];
  assign sel_stock = stock_q[sel_idx_i];

  // Next-state and registered-output logic for the vending FSM.
  always_comb begin
    logic collecting;
    logic vend_take;

    state_d       = state_q;
    credit_d      = credit_q;
    stock_d       = stock_q;
    timer_d       = timer_q;
    coin_reject_d = 1'b0;
    vend_valid_d  = 1'b0;
    vend_idx_d    = vend_idx_q;
    sel_err_d     = ERR_NONE;
    collecting    = (state_q == S_COLLECT);
    vend_take     = 1'b0;

    case (state_q)
      S_IDLE, S_COLLECT: begin
        // Selection is judged on the stock seen before any same-cycle restock.
        if (sel_valid_i) begin
          if (!idx_ok)                 sel_err_d = ERR_INDEX;
          else if (sel_stock == '0)    sel_err_d = ERR_SOLDOUT;
          else if (credit_q < sel_price) sel_err_d = ERR_CREDIT;
          else                         vend_take = 1'b1;
        end

        if (!collecting && restock_i) begin
          for (int i = 0; i < N_PROD; i++) stock_d[i] = STOCK_INIT;
        end

        // Cancel only means something with credit held; in IDLE it is a no-op
        // and does not block a selection or coin in the same cycle.
        if (collecting && cancel_i) begin
          sel_err_d     = ERR_NONE;
          state_d       = S_CHANGE;
          timer_d       = '0;
          coin_reject_d = coin_valid_i;
        end else if (vend_take) begin
          state_d             = S_VEND;
          vend_valid_d        = 1'b1;
          vend_idx_d          = sel_idx_i;
          stock_d[sel_idx_i]  = stock_d[sel_idx_i] - STOCK_W'(1);
          credit_d            = credit_q - sel_price;
          timer_d             = '0;
          coin_reject_d       = coin_valid_i;
        end else if (coin_valid_i && coin_fits) begin
          credit_d = coin_sum[CREDIT_W-1:0];
          state_d  = S_COLLECT;
          timer_d  = '0;
        end else begin
          coin_reject_d = coin_valid_i;
          if (collecting) begin
            if (timer_q == TMR_LAST) begin
              state_d = S_CHANGE;
              timer_d = '0;
            end else begin
              timer_d = timer_q + TMR_W'(1);
            end
          end
        end
      end

      S_VEND: begin
        coin_reject_d = coin_valid_i;
        state_d       = (credit_q != '0) ? S_CHANGE : S_IDLE;
      end

      S_CHANGE: begin
        coin_reject_d = coin_valid_i;
        if (chg_ready_i) begin
          credit_d = credit_q - coin_val_a[chg_code_q];
          if (credit_d == '0) state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Offered coin tracks the remaining credit; it only moves on a handshake.
    chg_code_d = (state_d == S_CHANGE) ? largest_coin(credit_d) : chg_code_q;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      credit_q      <= '0;
      timer_q       <= '0;
      coin_reject_q <= 1'b0;
      vend_valid_q  <= 1'b0;
      vend_idx_q    <= '0;
      sel_err_q     <= ERR_NONE;
      chg_code_q    <= 2'd0;
      for (int i = 0; i < N_PROD; i++) stock_q[i] <= STOCK_INIT;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      timer_q       <= timer_d;
      coin_reject_q <= coin_reject_d;
      vend_valid_q  <= vend_valid_d;
      vend_idx_q    <= vend_idx_d;
      sel_err_q     <= sel_err_d;
      chg_code_q    <= chg_code_d;
      stock_q       <= stock_d;
    end
  end

  // Sold-out flags derive directly from the stock registers.
  always_comb begin
    sold_out_o = '0;
    for (int i = 0; i < N_PROD; i++) sold_out_o[i] = (stock_q[i] == '0);
  end

  assign coin_reject_o = coin_reject_q;
  assign vend_valid_o  = vend_valid_q;
  assign vend_idx_o    = vend_idx_q;
  assign sel_err_o     = sel_err_q;
  assign chg_valid_o   = (state_q == S_CHANGE);
  assign chg_code_o    = chg_code_q;
  assign credit_o      = credit_q;
  assign busy_o        = (state_q == S_VEND) || (state_q == S_CHANGE);

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Testbench for vend_ctrl_multi: directed scenarios plus randomized traffic against a reference model.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: chg_ready driven per cycle, randomly in the soak test.
`timescale 1ns/1ps
module tb_vend_ctrl_multi;
  localparam int NP   = 4;
  localparam int CW   = 8;
  localparam int INIT = 9;
  localparam logic [NP*CW-1:0] PR = {8'd50, 8'd40, 8'd30, 8'd20};
  localparam logic [4*CW-1:0]  CV = {8'd100, 8'd50, 8'd20, 8'd10};
  localparam int MAXC = 200;
  localparam int TO   = 300;

  logic clk = 1'b0;
  logic reset;
  logic coin_valid_i, sel_valid_i, cancel_i, restock_i, chg_ready_i;
  logic [1:0] coin_code_i, sel_idx_i;
  logic coin_reject_o, vend_valid_o, chg_valid_o, busy_o;
  logic [1:0] vend_idx_o, sel_err_o, chg_code_o;
  logic [CW-1:0] credit_o;
  logic [NP-1:0] sold_out_o;

  vend_ctrl_multi #(
    .N_PROD(NP), .CREDIT_W(CW), .STOCK_W(4), .INIT_STOCK(INIT),
    .PRICES(PR), .COIN_VALS(CV), .MAX_CREDIT(MAXC), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .coin_valid_i(coin_valid_i), .coin_code_i(coin_code_i),
    .sel_valid_i(sel_valid_i), .sel_idx_i(sel_idx_i),
    .cancel_i(cancel_i), .restock_i(restock_i), .chg_ready_i(chg_ready_i),
    .coin_reject_o(coin_reject_o), .vend_valid_o(vend_valid_o), .vend_idx_o(vend_idx_o),
    .sel_err_o(sel_err_o), .chg_valid_o(chg_valid_o), .chg_code_o(chg_code_o),
    .credit_o(credit_o), .sold_out_o(sold_out_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: credit as an integer, change as a queue of coins worked out up front.
  int m_credit;
  int m_stock [NP];
  bit m_vend_pend;
  int m_chg [$];
  int m_idle;
  int m_vidx;
  bit e_reject, e_vend;
  int e_err;

  function automatic int price(input int i);
    return int'(PR[i*CW +: CW]);
  endfunction

  function automatic int coinv(input int c);
    return int'(CV[c*CW +: CW]);
  endfunction

  function void model_reset();
    m_credit = 0;
    for (int i = 0; i < NP; i++) m_stock[i] = INIT;
    m_vend_pend = 0;
    m_chg.delete();
    m_idle = 0;
    m_vidx = 0;
    e_reject = 0; e_vend = 0; e_err = 0;
  endfunction

  function void start_change();
    int rem;
    rem = m_credit;
    m_chg.delete();
    for (int c = 3; c >= 0; c--) begin
      while (rem >= coinv(c)) begin
        m_chg.push_back(c);
        rem -= coinv(c);
      end
    end
  endfunction

  function void model_step(input bit cv, input int cc, input bit sv, input int si,
                           input bit ca, input bit rs, input bit cr);
    bit holding, took;
    e_reject = 0; e_vend = 0; e_err = 0;
    if (m_vend_pend) begin
      m_vend_pend = 0;
      e_reject = cv;
      if (m_credit > 0) start_change();
    end else if (m_chg.size() > 0) begin
      e_reject = cv;
      if (cr) begin
        m_credit -= coinv(m_chg[0]);
        void'(m_chg.pop_front());
      end
    end else begin
      holding = (m_credit > 0);
      took = 0;
      if (sv) begin
        if (si >= NP) e_err = 3;
        else if (m_stock[si] == 0) e_err = 1;
        else if (m_credit < price(si)) e_err = 2;
        else took = 1;
      end
      if (!holding && rs) for (int i = 0; i < NP; i++) m_stock[i] = INIT;
      if (holding && ca) begin
        e_err = 0; e_reject = cv; m_idle = 0;
        start_change();
      end else if (took) begin
        e_vend = 1; m_vidx = si; m_stock[si] -= 1; m_credit -= price(si);
        m_vend_pend = 1; e_reject = cv; m_idle = 0;
      end else if (cv && (m_credit + coinv(cc) <= MAXC)) begin
        m_credit += coinv(cc);
        m_idle = 0;
      end else begin
        e_reject = cv;
        if (holding) begin
          m_idle++;
          if (m_idle == TO) begin
            m_idle = 0;
            start_change();
          end
        end
      end
    end
  endfunction

  task automatic tick(input bit cv, input int cc, input bit sv, input int si,
                      input bit ca, input bit rs, input bit cr);
    coin_valid_i = cv; coin_code_i = 2'(cc);
    sel_valid_i  = sv; sel_idx_i   = 2'(si);
    cancel_i = ca; restock_i = rs; chg_ready_i = cr;
    if (reset) model_reset();
    else model_step(cv, cc, sv, si, ca, rs, cr);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(1, 3, 1, 1, 1, 1, 1);
    tick(1, 2, 1, 2, 1, 0, 1);
    n_checks++; if (credit_o !== 8'd0) begin n_fail++; $display("FAIL reset_credit got=%0d exp=0", credit_o); end
    n_checks++; if (sold_out_o !== 4'b0000) begin n_fail++; $display("FAIL reset_sold_out got=%b exp=0000", sold_out_o); end
    n_checks++; if ({busy_o, chg_valid_o, vend_valid_o, coin_reject_o} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags got=%b exp=0000", {busy_o, chg_valid_o, vend_valid_o, coin_reject_o}); end
    n_checks++; if ({sel_err_o, vend_idx_o, chg_code_o} !== 6'd0) begin
      n_fail++; $display("FAIL reset_codes got=%b exp=000000", {sel_err_o, vend_idx_o, chg_code_o}); end
    reset = 1'b0;
  endtask

  // Product 1 costs 30 with this price table: 70 - 30 leaves 40, paid back as 20 + 20.
  task automatic test_vend_change();
    tick(1, 2, 0, 0, 0, 0, 0);
    n_checks++; if (credit_o !== 8'd50) begin n_fail++; $display("FAIL t1_credit50 got=%0d exp=50", credit_o); end
    tick(1, 1, 0, 0, 0, 0, 0);
    n_checks++; if (credit_o !== 8'd70) begin n_fail++; $display("FAIL t1_credit70 got=%0d exp=70", credit_o); end
    tick(0, 0, 1, 1, 0, 0, 0);
    n_checks++; if ({vend_valid_o, vend_idx_o, busy_o} !== 4'b1011) begin
      n_fail++; $display("FAIL t1_vend got=%b exp=1011", {vend_valid_o, vend_idx_o, busy_o}); end
    n_checks++; if (credit_o !== 8'd40) begin n_fail++; $display("FAIL t1_credit40 got=%0d exp=40", credit_o); end
    tick(0, 0, 0, 0, 0, 0, 1);
    n_checks++; if ({vend_valid_o, chg_valid_o, chg_code_o} !== 4'b0101) begin
      n_fail++; $display("FAIL t1_chg_first got=%b exp=0101", {vend_valid_o, chg_valid_o, chg_code_o}); end
    tick(0, 0, 0, 0, 0, 0, 1);
    n_checks++; if ({credit_o, chg_valid_o, chg_code_o} !== {8'd20, 1'b1, 2'd1}) begin
      n_fail++; $display("FAIL t1_chg_second got=%0d/%b/%0d exp=20/1/1", credit_o, chg_valid_o, chg_code_o); end
    tick(0, 0, 0, 0, 0, 0, 1);
    n_checks++; if ({credit_o, chg_valid_o, busy_o} !== {8'd0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL t1_idle got=%0d/%b/%b exp=0/0/0", credit_o, chg_valid_o, busy_o); end
  endtask

  task automatic test_credit_limit();
    tick(1, 3, 0, 0, 0, 0, 0);
    tick(1, 3, 0, 0, 0, 0, 0);
    n_checks++; if (credit_o !== 8'd200) begin n_fail++; $display("FAIL t2_credit200 got=%0d exp=200", credit_o); end
    tick(1, 0, 0, 0, 0, 0, 0);
    n_checks++; if ({coin_reject_o, credit_o} !== {1'b1, 8'd200}) begin
      n_fail++; $display("FAIL t2_over_limit got=%b/%0d exp=1/200", coin_reject_o, credit_o); end
    tick(0, 0, 1, 3, 0, 0, 0);
    n_checks++; if ({coin_reject_o, vend_valid_o, vend_idx_o, credit_o} !== {1'b0, 1'b1, 2'd3, 8'd150}) begin
      n_fail++; $display("FAIL t2_vend got=%b/%b/%0d/%0d exp=0/1/3/150", coin_reject_o, vend_valid_o, vend_idx_o, credit_o); end
    tick(0, 0, 0, 0, 0, 0, 1);
    n_checks++; if ({chg_valid_o, chg_code_o} !== 3'b111) begin
      n_fail++; $display("FAIL t2_chg100 got=%b/%0d exp=1/3", chg_valid_o, chg_code_o); end
    tick(0, 0, 0, 0, 0, 0, 1);
    n_checks++; if ({chg_valid_o, chg_code_o, credit_o} !== {1'b1, 2'd2, 8'd50}) begin
      n_fail++; $display("FAIL t2_chg50 got=%b/%0d/%0d exp=1/2/50", chg_valid_o, chg_code_o, credit_o); end
    tick(0, 0, 0, 0, 0, 0, 1);
    n_checks++; if ({chg_valid_o, credit_o} !== {1'b0, 8'd0}) begin
      n_fail++; $display("FAIL t2_done got=%b/%0d exp=0/0", chg_valid_o, credit_o); end
  endtask

  task automatic test_sold_out();
    int vends = 0;
    for (int k = 0; k < INIT; k++) begin
      tick(1, 1, 0, 0, 0, 0, 0);
      tick(0, 0, 1, 0, 0, 0, 0);
      if (vend_valid_o === 1'b1) vends++;
      tick(0, 0, 0, 0, 0, 0, 0);
    end
    n_checks++; if (vends != INIT) begin n_fail++; $display("FAIL t3_vend_count got=%0d exp=%0d", vends, INIT); end
    n_checks++; if (sold_out_o !== 4'b0001) begin n_fail++; $display("FAIL t3_sold_out got=%b exp=0001", sold_out_o); end
    tick(1, 1, 0, 0, 0, 0, 0);
    tick(0, 0, 1, 0, 0, 0, 0);
    n_checks++; if ({sel_err_o, vend_valid_o, credit_o} !== {2'd1, 1'b0, 8'd20}) begin
      n_fail++; $display("FAIL t3_err_soldout got=%0d/%b/%0d exp=1/0/20", sel_err_o, vend_valid_o, credit_o); end
    tick(0, 0, 0, 0, 1, 0, 0);
    n_checks++; if ({chg_valid_o, chg_code_o, sel_err_o} !== {1'b1, 2'd1, 2'd0}) begin
      n_fail++; $display("FAIL t3_cancel got=%b/%0d/%0d exp=1/1/0", chg_valid_o, chg_code_o, sel_err_o); end
    tick(1, 0, 0, 0, 0, 1, 1);
    n_checks++; if ({coin_reject_o, chg_valid_o, credit_o, sold_out_o} !== {1'b1, 1'b0, 8'd0, 4'b0001}) begin
      n_fail++; $display("FAIL t3_restock_in_change got=%b/%b/%0d/%b exp=1/0/0/0001", coin_reject_o, chg_valid_o, credit_o, sold_out_o); end
    tick(0, 0, 0, 0, 0, 1, 0);
    n_checks++; if (sold_out_o !== 4'b0000) begin n_fail++; $display("FAIL t3_restock got=%b exp=0000", sold_out_o); end
  endtask

  task automatic test_insufficient_and_back_to_back();
    tick(1, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 1, 0, 0, 0, 0);
    n_checks++; if ({sel_err_o, credit_o} !== {2'd2, 8'd10}) begin
      n_fail++; $display("FAIL t4_err_credit got=%0d/%0d exp=2/10", sel_err_o, credit_o); end
    tick(1, 0, 0, 0, 0, 0, 0);
    tick(1, 1, 1, 0, 0, 0, 0);
    n_checks++; if ({vend_valid_o, coin_reject_o, credit_o} !== {1'b1, 1'b1, 8'd0}) begin
      n_fail++; $display("FAIL t4_sel_and_coin got=%b/%b/%0d exp=1/1/0", vend_valid_o, coin_reject_o, credit_o); end
    tick(1, 2, 0, 0, 0, 0, 0);
    n_checks++; if ({coin_reject_o, credit_o, busy_o} !== {1'b1, 8'd0, 1'b0}) begin
      n_fail++; $display("FAIL t4_coin_in_vend got=%b/%0d/%b exp=1/0/0", coin_reject_o, credit_o, busy_o); end
  endtask

  task automatic test_timeout();
    tick(1, 1, 0, 0, 0, 0, 0);
    repeat (TO - 1) tick(0, 0, 0, 0, 0, 0, 0);
    n_checks++; if (chg_valid_o !== 1'b0) begin n_fail++; $display("FAIL t5_early got=%b exp=0", chg_valid_o); end
    tick(0, 0, 0, 0, 0, 0, 0);
    n_checks++; if ({chg_valid_o, chg_code_o} !== 3'b101) begin
      n_fail++; $display("FAIL t5_timeout got=%b/%0d exp=1/1", chg_valid_o, chg_code_o); end
    for (int k = 0; k < 5; k++) begin
      tick(0, 0, 0, 0, 0, 0, 0);
      n_checks++; if ({chg_valid_o, chg_code_o, credit_o} !== {1'b1, 2'd1, 8'd20}) begin
        n_fail++; $display("FAIL t5_hold%0d got=%b/%0d/%0d exp=1/1/20", k, chg_valid_o, chg_code_o, credit_o); end
    end
    tick(0, 0, 0, 0, 0, 0, 1);
    n_checks++; if ({chg_valid_o, credit_o} !== {1'b0, 8'd0}) begin
      n_fail++; $display("FAIL t5_done got=%b/%0d exp=0/0", chg_valid_o, credit_o); end
  endtask

  task automatic test_reset_in_change();
    tick(1, 3, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 1, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 0);
    n_checks++; if (chg_valid_o !== 1'b1) begin n_fail++; $display("FAIL t6_in_change got=%b exp=1", chg_valid_o); end
    reset = 1'b1;
    tick(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    n_checks++; if ({chg_valid_o, busy_o, credit_o, sold_out_o} !== {1'b0, 1'b0, 8'd0, 4'b0000}) begin
      n_fail++; $display("FAIL t6_reset got=%b/%b/%0d/%b exp=0/0/0/0000", chg_valid_o, busy_o, credit_o, sold_out_o); end
  endtask

  task automatic test_random();
    logic [NP-1:0] e_so;
    for (int n = 0; n < 4000; n++) begin
      tick(($urandom_range(0, 99) < 25), $urandom_range(0, 3),
           ($urandom_range(0, 99) < 12), $urandom_range(0, 3),
           ($urandom_range(0, 99) < 4),  ($urandom_range(0, 99) < 2),
           ($urandom_range(0, 99) < 60));
      for (int i = 0; i < NP; i++) e_so[i] = (m_stock[i] == 0);
      n_checks++; if (credit_o !== 8'(m_credit)) begin
        n_fail++; $display("FAIL rnd_credit cyc=%0d got=%0d exp=%0d", n, credit_o, m_credit); end
      n_checks++; if ({coin_reject_o, vend_valid_o, sel_err_o} !== {e_reject, e_vend, 2'(e_err)}) begin
        n_fail++; $display("FAIL rnd_pulses cyc=%0d got=%b/%b/%0d exp=%b/%b/%0d", n, coin_reject_o, vend_valid_o, sel_err_o, e_reject, e_vend, e_err); end
      n_checks++; if (vend_idx_o !== 2'(m_vidx)) begin
        n_fail++; $display("FAIL rnd_vend_idx cyc=%0d got=%0d exp=%0d", n, vend_idx_o, m_vidx); end
      n_checks++; if ({chg_valid_o, busy_o} !== {(m_chg.size() > 0), (m_vend_pend || m_chg.size() > 0)}) begin
        n_fail++; $display("FAIL rnd_chg_busy cyc=%0d got=%b/%b exp=%0d/%0d", n, chg_valid_o, busy_o, m_chg.size() > 0, m_vend_pend); end
      if (m_chg.size() > 0) begin
        n_checks++; if (chg_code_o !== 2'(m_chg[0])) begin
          n_fail++; $display("FAIL rnd_chg_code cyc=%0d got=%0d exp=%0d", n, chg_code_o, m_chg[0]); end
      end
      n_checks++; if (sold_out_o !== e_so) begin
        n_fail++; $display("FAIL rnd_sold_out cyc=%0d got=%b exp=%b", n, sold_out_o, e_so); end
    end
  endtask

  initial begin
    reset = 1'b1;
    coin_valid_i = 0; coin_code_i = 0; sel_valid_i = 0; sel_idx_i = 0;
    cancel_i = 0; restock_i = 0; chg_ready_i = 0;
    model_reset();
    test_reset();
    test_vend_change();
    test_credit_limit();
    test_sold_out();
    test_insufficient_and_back_to_back();
    test_timeout();
    test_reset_in_change();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
